// File: rtl/mem_stage_unit.sv
// MEM-stage access unit: sequences word/byte loads and stores onto the
// data cache Rd/Wr/Done handshake and stalls the pipeline until completion.
module mem_stage_unit #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 63
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              ByteOp,
    input  logic              SignExt,
    input  logic              createdump,
    output logic [DATA_W-1:0] MemOut,
    output logic              MemStall,
    output logic              err,
    output logic [ADDR_W-1:0] C_Addr,
    output logic [DATA_W-1:0] C_DataIn,
    output logic              C_Rd,
    output logic              C_Wr,
    output logic              C_createdump,
    input  logic [DATA_W-1:0] C_DataOut,
    input  logic              C_Done,
    input  logic              C_Err
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RMW_RD,
        S_RMW_WR,
        S_WR
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_byte;
    logic              r_sext;
    logic [DATA_W-1:0] r_merge;
    logic [DATA_W-1:0] r_memout;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_req;
    logic              w_bad;
    logic              w_to;
    logic              w_stall;
    logic              w_rd;
    logic              w_wr;
    logic [DATA_W-1:0] w_din;
    logic              w_seterr;
    logic              w_accept;
    logic              w_ldone;
    logic [OFF_W-1:0]  w_lane;
    logic [OFF_W+2:0]  w_sh;
    logic [7:0]        w_rbyte;
    logic [DATA_W-1:0] w_fmt;
    logic [DATA_W-1:0] w_merged;

    assign w_req   = MemRead | MemWrite;
    assign w_bad   = (MemRead & MemWrite) |
                     (!ByteOp && (Addr[OFF_W-1:0] != '0));
    assign w_to    = (r_cnt == CNT_W'(TIMEOUT));
    assign w_lane  = r_addr[OFF_W-1:0];
    assign w_sh    = {w_lane, 3'b000};
    assign w_rbyte = C_DataOut[w_sh +: 8];
    assign w_fmt   = r_byte ?
                     {{(DATA_W-8){r_sext & w_rbyte[7]}}, w_rbyte} :
                     C_DataOut;

    // Read data with the latched store byte dropped into its lane
    always_comb begin
        w_merged = C_DataOut;
        w_merged[w_sh +: 8] = r_wdata[7:0];
    end

    always_comb begin
        w_next   = r_state;
        w_stall  = 1'b0;
        w_rd     = 1'b0;
        w_wr     = 1'b0;
        w_din    = '0;
        w_seterr = C_Err;
        w_accept = 1'b0;
        w_ldone  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!C_Err && w_req) begin
                    if (w_bad) begin
                        w_seterr = 1'b1;
                    end else begin
                        w_accept = 1'b1;
                        w_stall  = 1'b1;
                        if (MemRead)     w_next = S_RD;
                        else if (ByteOp) w_next = S_RMW_RD;
                        else             w_next = S_WR;
                    end
                end
            end
            default: begin
                w_rd = !w_to &&
                       (r_state == S_RD || r_state == S_RMW_RD);
                w_wr = !w_to &&
                       (r_state == S_WR || r_state == S_RMW_WR);
                if (r_state == S_WR)     w_din = r_wdata;
                if (r_state == S_RMW_WR) w_din = r_merge;
                if (C_Err) begin
                    w_next = S_IDLE;
                end else if (w_to) begin
                    w_seterr = 1'b1;
                    w_next   = S_IDLE;
                end else if (C_Done) begin
                    if (r_state == S_RMW_RD) begin
                        w_next  = S_RMW_WR;
                        w_stall = 1'b1;
                    end else begin
                        w_next  = S_IDLE;
                        w_ldone = (r_state == S_RD);
                    end
                end else begin
                    w_stall = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_byte   <= 1'b0;
            r_sext   <= 1'b0;
            r_merge  <= '0;
            r_memout <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next;
            if (w_seterr) r_err <= 1'b1;
            if (w_accept) begin
                r_addr  <= Addr;
                r_wdata <= WriteData;
                r_byte  <= ByteOp;
                r_sext  <= SignExt;
            end
            if (w_ldone) r_memout <= w_fmt;
            if (r_state == S_RMW_RD && w_next == S_RMW_WR)
                r_merge <= w_merged;
            // Fresh budget on every state entry
            if (w_next != r_state)
                r_cnt <= '0;
            else if (r_state != S_IDLE && !C_Done)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign MemOut       = w_ldone ? w_fmt : r_memout;
    assign MemStall     = w_stall;
    assign err          = r_err;
    assign C_Addr       = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign C_DataIn     = w_din;
    assign C_Rd         = w_rd;
    assign C_Wr         = w_wr;
    assign C_createdump = createdump;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Bench for mem_stage_unit: directed requests drive a scripted cache;
// a monitor checks every cache handshake beat against a scoreboard.
module tb_mem_stage_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Addr;
    logic [15:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic        ByteOp;
    logic        SignExt;
    logic        createdump;
    logic [15:0] MemOut;
    logic        MemStall;
    logic        err;
    logic [15:0] C_Addr;
    logic [15:0] C_DataIn;
    logic        C_Rd;
    logic        C_Wr;
    logic        C_createdump;
    logic [15:0] C_DataOut;
    logic        C_Done;
    logic        C_Err;

    mem_stage_unit #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(63)) dut (
        .clk(clk), .rst(rst), .Addr(Addr), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .ByteOp(ByteOp),
        .SignExt(SignExt), .createdump(createdump), .MemOut(MemOut),
        .MemStall(MemStall), .err(err), .C_Addr(C_Addr),
        .C_DataIn(C_DataIn), .C_Rd(C_Rd), .C_Wr(C_Wr),
        .C_createdump(C_createdump), .C_DataOut(C_DataOut),
        .C_Done(C_Done), .C_Err(C_Err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic        stall;
        logic        chk_out;
        logic [15:0] out;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   vecs = 0;
    int   errs = 0;
    int   stall_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic rd, input logic wr,
                                input logic [15:0] a, input logic [15:0] d,
                                input logic st, input logic co,
                                input logic [15:0] o);
        exp_t e;
        e.rd = rd; e.wr = wr; e.addr = a; e.din = d;
        e.stall = st; e.chk_out = co; e.out = o;
        return e;
    endfunction

    always @(negedge clk) if (MemStall) stall_cnt++;

    always @(negedge clk) begin
        if (!rst && C_Done && (C_Rd || C_Wr)) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", {C_Rd, C_Wr}, 0);
            end else begin
                me = sb.pop_front();
                chk("beat_rd", C_Rd, me.rd);
                chk("beat_wr", C_Wr, me.wr);
                chk("beat_addr", C_Addr, me.addr);
                chk("beat_stall", MemStall, me.stall);
                if (me.wr) chk("beat_din", C_DataIn, me.din);
                if (me.chk_out) chk("beat_memout", MemOut, me.out);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic rd, input logic wr, input logic bop,
                       input logic sx, input logic [15:0] a,
                       input logic [15:0] wd);
        MemRead = rd; MemWrite = wr; ByteOp = bop; SignExt = sx;
        Addr = a; WriteData = wd;
        stall_cnt = 0;
    endtask

    task automatic go();
        tick();
        MemRead = 1'b0;
        MemWrite = 1'b0;
    endtask

    task automatic respond(input int lat, input logic [15:0] d);
        repeat (lat - 1) tick();
        C_Done = 1'b1;
        C_DataOut = d;
        tick();
        C_Done = 1'b0;
        C_DataOut = 16'h0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic saw_wr;
        rst = 1'b1; Addr = '0; WriteData = '0; MemRead = 0; MemWrite = 0;
        ByteOp = 0; SignExt = 0; createdump = 0; C_DataOut = '0;
        C_Done = 0; C_Err = 0;
        repeat (3) tick();
        chk("rst_memout", MemOut, 16'h0000);
        chk("rst_stall", MemStall, 0);
        chk("rst_err", err, 0);
        chk("rst_crdwr", {C_Rd, C_Wr}, 0);
        rst = 1'b0;
        createdump = 1'b1;
        tick();
        chk("createdump", C_createdump, 1);
        createdump = 1'b0;

        sb.push_back(mk(1, 0, 16'h0010, 0, 0, 1, 16'hBEEF));
        req(1, 0, 0, 0, 16'h0010, 0);
        go();
        respond(3, 16'hBEEF);
        chk("wl_stall_cycles", stall_cnt, 3);
        repeat (3) tick();
        chk("wl_memout_held", MemOut, 16'hBEEF);

        sb.push_back(mk(1, 0, 16'h0010, 0, 0, 1, 16'hFF80));
        req(1, 0, 1, 1, 16'h0011, 0);
        go();
        respond(1, 16'h807F);
        chk("bl_stall_cycles", stall_cnt, 1);
        chk("bl_sext_memout", MemOut, 16'hFF80);

        sb.push_back(mk(1, 0, 16'h0010, 0, 0, 1, 16'h0080));
        req(1, 0, 1, 0, 16'h0011, 0);
        go();
        respond(2, 16'h807F);

        sb.push_back(mk(1, 0, 16'h0012, 0, 0, 1, 16'hFFF5));
        req(1, 0, 1, 1, 16'h0012, 0);
        go();
        respond(1, 16'h12F5);

        sb.push_back(mk(1, 0, 16'h0020, 0, 1, 0, 0));
        sb.push_back(mk(0, 1, 16'h0020, 16'h12AB, 0, 0, 0));
        req(0, 1, 1, 0, 16'h0020, 16'h00AB);
        go();
        respond(2, 16'h1234);
        respond(1, 16'h0000);
        chk("bs_stall_cycles", stall_cnt, 3);
        chk("bs_memout_kept", MemOut, 16'hFFF5);

        sb.push_back(mk(1, 0, 16'h0020, 0, 1, 0, 0));
        sb.push_back(mk(0, 1, 16'h0020, 16'hCD34, 0, 0, 0));
        req(0, 1, 1, 0, 16'h0021, 16'h55CD);
        go();
        respond(1, 16'h1234);
        respond(1, 16'h0000);

        sb.push_back(mk(0, 1, 16'h0040, 16'hCAFE, 0, 0, 0));
        req(0, 1, 0, 0, 16'h0040, 16'hCAFE);
        go();
        respond(2, 16'h0000);
        chk("ok_err_clear", err, 0);

        req(1, 0, 0, 0, 16'h0003, 0);
        chk("mis_stall_now", MemStall, 0);
        go();
        chk("mis_err", err, 1);
        chk("mis_crdwr", {C_Rd, C_Wr}, 0);
        chk("mis_stall", MemStall, 0);

        do_reset();
        chk("rst2_err", err, 0);
        req(1, 1, 0, 0, 16'h0010, 16'h1111);
        chk("rw_stall_now", MemStall, 0);
        go();
        chk("rw_err", err, 1);
        chk("rw_crdwr", {C_Rd, C_Wr}, 0);

        sb.push_back(mk(1, 0, 16'h0070, 0, 0, 1, 16'h4321));
        req(1, 0, 0, 0, 16'h0070, 0);
        go();
        respond(1, 16'h4321);
        chk("after_err_memout", MemOut, 16'h4321);
        chk("err_sticky", err, 1);

        do_reset();
        req(1, 0, 0, 0, 16'h0080, 0);
        go();
        C_Err = 1'b1;
        tick();
        C_Err = 1'b0;
        chk("cerr_err", err, 1);
        chk("cerr_idle", {C_Rd, MemStall}, 0);

        do_reset();
        req(0, 1, 0, 0, 16'h0050, 16'h1111);
        go();
        chk("to_wr_active", {C_Wr, MemStall}, 2'b11);
        n = 0;
        while (MemStall && n < 200) begin
            tick();
            n++;
        end
        chk("to_cycles", n, 63);
        chk("to_wr_dropped", C_Wr, 0);
        tick();
        chk("to_err", err, 1);
        chk("to_stall", MemStall, 0);
        sb.push_back(mk(1, 0, 16'h0060, 0, 0, 1, 16'h1357));
        req(1, 0, 0, 0, 16'h0060, 0);
        go();
        respond(1, 16'h1357);
        chk("to_next_load", MemOut, 16'h1357);

        req(0, 1, 1, 0, 16'h0031, 16'h00EE);
        go();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_outs", {MemStall, C_Rd, C_Wr, err}, 0);
        chk("mid_rst_memout", MemOut, 16'h0000);
        saw_wr = 1'b0;
        repeat (5) begin
            tick();
            if (C_Wr) saw_wr = 1'b1;
        end
        chk("mid_rst_no_wr", saw_wr, 0);

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
